posit_encoder: RTL and testbench

- Sequential encoder that packs decoded posit fields into an N-bit posit word. Fields are sign, regime k, exponent and fraction, as produced by the arithmetic cores.
- Inverse of the decode side. Sits at the output of the arithmetic cores (e.g. multiply) and drives the result bus.
- Builds the posit body serially, one bit per clock, applies round-to-nearest-even, then two's-complements negative results.
- Valid/ready handshakes on both sides.

---
 rtl/posit_encoder.sv | 174 +++++++++++++++++
 tb/tb_posit_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/posit_encoder.sv
// rtl/posit_encoder.sv - serial posit packer: regime/exponent/fraction stream, RNE rounding, sign.
module posit_encoder #(
  parameter int N  = 8,
  parameter int ES = 0,
  parameter int S  = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_is_zero,
  input  logic                        in_is_inf,
  input  logic                        in_sign,
  input  logic [N-1:0]                in_k,
  input  logic [((ES>0)?ES:1)-1:0]    in_exp,
  input  logic [N-1:0]                in_mant,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                out_posit,
  output logic                        out_inexact
);

  localparam int PW = ES + N;
  localparam logic signed [N-1:0] K_MAX = N'(N - 2);
  localparam logic signed [N-1:0] K_MIN = N'(2 - N);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic           sign_q;
  logic           run_bit;
  logic [N-1:0]   run_left;
  logic           term_done;
  logic [PW-1:0]  payload;
  logic [N-1:0]   shreg;
  logic [S-1:0]   cnt;

  // Exponent and fraction travel together as one payload after the regime.
  logic [PW-1:0]  load_payload;
  if (ES > 0) begin : g_exp
    assign load_payload = {in_exp, in_mant};
  end else begin : g_noexp
    logic unused_exp;
    assign unused_exp   = ^in_exp;
    assign load_payload = in_mant;
  end

  logic signed [N-1:0] k_in, k_clamped;
  logic                k_neg;
  logic [N-1:0]        load_run;

  assign k_in = in_k;

  always_comb begin
    k_clamped = k_in;
    if (k_in > K_MAX)
      k_clamped = K_MAX;
    else if (k_in < K_MIN)
      k_clamped = K_MIN;
  end

  // k>=0 emits k+1 ones; k<0 emits -k zeros; the terminator follows either run.
  assign k_neg    = k_clamped[N-1];
  assign load_run = k_neg ? ('0 - $unsigned(k_clamped))
                          : ($unsigned(k_clamped) + N'(1));

  logic stream_bit;
  always_comb begin
    stream_bit = payload[PW-1];
    if (run_left != '0)
      stream_bit = run_bit;
    else if (!term_done)
      stream_bit = ~run_bit;
  end

  logic [N-2:0] body, body_rnd;
  logic         guard, sticky, round_up;
  logic [N-1:0] sum, mag, posit_rnd;

  always_comb begin
    body     = shreg[N-1:1];
    guard    = shreg[0];
    sticky   = |payload;
    round_up = guard & (body[0] | sticky);
    sum      = {1'b0, body} + {{(N-1){1'b0}}, round_up};
    // Carry out of the body would reach the sign position: pin to maxpos.
    body_rnd  = sum[N-1] ? '1 : sum[N-2:0];
    mag       = {1'b0, body_rnd};
    posit_rnd = sign_q ? (~mag + N'(1)) : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = (in_is_inf || in_is_zero) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt == S'(N - 1))
          state_nxt = ROUND;
      end
      ROUND: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      run_bit     <= 1'b0;
      run_left    <= '0;
      term_done   <= 1'b0;
      payload     <= '0;
      shreg       <= '0;
      cnt         <= '0;
      out_posit   <= '0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q      <= in_sign;
            out_inexact <= 1'b0;
            if (in_is_inf) begin
              out_posit <= {1'b1, {(N-1){1'b0}}};
            end else if (in_is_zero) begin
              out_posit <= '0;
            end else begin
              run_bit   <= ~k_neg;
              run_left  <= load_run;
              term_done <= 1'b0;
              payload   <= load_payload;
              shreg     <= '0;
              cnt       <= '0;
            end
          end
        end
        SHIFT: begin
          shreg <= {shreg[N-2:0], stream_bit};
          cnt   <= cnt + S'(1);
          if (run_left != '0)
            run_left <= run_left - N'(1);
          else if (!term_done)
            term_done <= 1'b1;
          else
            payload <= {payload[PW-2:0], 1'b0};
        end
        ROUND: begin
          out_posit   <= posit_rnd;
          out_inexact <= guard | sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// tb/tb_posit_encoder.sv - directed and randomized checks of posit_encoder against a bit-queue model.
module tb_posit_encoder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_is_zero = 1'b0;
  logic         in_is_inf = 1'b0;
  logic         in_sign = 1'b0;
  logic [N-1:0] in_k = '0;
  logic [0:0]   in_exp = '0;
  logic [N-1:0] in_mant = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_posit;
  logic         out_inexact;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  posit_encoder #(.N(N), .ES(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_zero(in_is_zero), .in_is_inf(in_is_inf), .in_sign(in_sign),
    .in_k(in_k), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit), .out_inexact(out_inexact)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Build the stream as a bit queue, cut it at N-1 body bits, round, saturate, negate.
  function automatic void model(input logic s, input int k, input logic [N-1:0] m,
                                input logic z, input logic inf,
                                output logic [N-1:0] p, output logic inx);
    bit q[$];
    int kc, body, maxbody;
    bit g, st;
    if (inf) begin p = 8'h80; inx = 1'b0; return; end
    if (z)   begin p = 8'h00; inx = 1'b0; return; end
    kc = (k > N-2) ? N-2 : ((k < -(N-2)) ? -(N-2) : k);
    if (kc >= 0) begin
      for (int i = 0; i < kc + 1; i++) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      for (int i = 0; i < -kc; i++) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    for (int i = N-1; i >= 0; i--) q.push_back(m[i]);
    while (q.size() < N) q.push_back(1'b0);
    body = 0;
    for (int i = 0; i < N-1; i++) body = body * 2 + int'(q[i]);
    g  = q[N-1];
    st = 1'b0;
    for (int i = N; i < q.size(); i++) st = st | q[i];
    if (g && ((body % 2) == 1 || st)) body++;
    maxbody = (1 << (N-1)) - 1;
    if (body > maxbody) body = maxbody;
    inx = g | st;
    p = s ? N'(((1 << N) - body) % (1 << N)) : N'(body);
  endfunction

  // Called at posedge+1; returns at posedge+1 with the encoder back in IDLE.
  task automatic run(input string tag, input logic s, input int k, input logic [N-1:0] m,
                     input logic z, input logic inf, input logic [N-1:0] exp_p,
                     input logic exp_x, input int exp_lat, input int stall);
    int lat;
    logic [N-1:0] held;
    check({tag, " in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1; in_sign = s; in_k = N'(k); in_mant = m;
    in_is_zero = z; in_is_inf = inf; in_exp = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_zero = 1'b0; in_is_inf = 1'b0;
    in_k = N'($urandom); in_mant = N'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " posit"}, out_posit, exp_p);
    check({tag, " inexact"}, out_inexact, exp_x);
    held = out_posit;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, " stall_valid"}, out_valid, 1'b1);
      check({tag, " stall_posit"}, out_posit, held);
      check({tag, " stall_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, out_valid, 1'b0);
  endtask

  typedef struct {
    string       tag;
    logic        s;
    int          k;
    logic [7:0]  m;
    logic        z;
    logic        inf;
    logic [7:0]  p;
    logic        x;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [N-1:0] mp;
    logic         mx;
    int           seen;

    vecs.push_back('{"two",       0,   1, 8'h00, 0, 0, 8'h60, 0, 10});
    vecs.push_back('{"four_half", 0,   2, 8'h20, 0, 0, 8'h71, 0, 10});
    vecs.push_back('{"eight",     0,   3, 8'h00, 0, 0, 8'h78, 0, 10});
    vecs.push_back('{"neg_two",   1,   1, 8'h00, 0, 0, 8'hA0, 0, 10});
    vecs.push_back('{"rnd_up",    0,   0, 8'h0C, 0, 0, 8'h42, 1, 10});
    vecs.push_back('{"rnd_tie",   0,   0, 8'h04, 0, 0, 8'h40, 1, 10});
    vecs.push_back('{"rnd_st",    0,   0, 8'h06, 0, 0, 8'h41, 1, 10});
    vecs.push_back('{"k_big",     0,  10, 8'h00, 0, 0, 8'h7F, 0, 10});
    vecs.push_back('{"k6_ff",     0,   6, 8'hFF, 0, 0, 8'h7F, 1, 10});
    vecs.push_back('{"k_small",   0, -10, 8'h00, 0, 0, 8'h01, 0, 10});
    vecs.push_back('{"k_small_n", 1, -10, 8'h00, 0, 0, 8'hFF, 0, 10});
    vecs.push_back('{"zero",      0,   3, 8'h55, 1, 0, 8'h00, 0, 1});
    vecs.push_back('{"inf",       1,   3, 8'h55, 0, 1, 8'h80, 0, 1});
    vecs.push_back('{"inf_zero",  0,   0, 8'h00, 1, 1, 8'h80, 0, 1});

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_posit", out_posit, 8'h00);
    check("rst_out_inexact", out_inexact, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("stall", 0, 2, 8'h20, 0, 0, 8'h71, 0, 10, 5);
    foreach (vecs[i])
      run(vecs[i].tag, vecs[i].s, vecs[i].k, vecs[i].m, vecs[i].z, vecs[i].inf,
          vecs[i].p, vecs[i].x, vecs[i].lat, 0);

    for (int i = 0; i < 60; i++) begin
      logic s, z, inf;
      int k;
      logic [N-1:0] m;
      s   = 1'($urandom);
      k   = $urandom_range(20) - 10;
      m   = N'($urandom);
      z   = ($urandom_range(15) == 0);
      inf = ($urandom_range(15) == 0);
      model(s, k, m, z, inf, mp, mx);
      run($sformatf("rand%0d", i), s, k, m, z, inf, mp, mx,
          (z || inf) ? 1 : N + 2, $urandom_range(3));
    end

    // Reset in the middle of SHIFT abandons the encode.
    in_valid = 1'b1; in_sign = 1'b0; in_k = 8'd1; in_mant = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_posit", out_posit, 8'h00);
    check("midrst_out_inexact", out_inexact, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);

    model(1'b1, 2, 8'h20, 1'b0, 1'b0, mp, mx);
    run("after_rst", 1'b1, 2, 8'h20, 1'b0, 1'b0, mp, mx, 10, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
